isa_cache_fill: RTL and testbench
=================================

ISA_CACHE_FILL -- requirements
Module: isa_cache_fill

Interface
REQ-001 Parameter ISA_WIDTH, default 30: instruction word width.
REQ-002 Parameter DDR_ADDR_WIDTH, default 28: word address width.
REQ-003 Parameter ISA_DEPTH, default 64: block size in words, power of two, range 2..512.
REQ-004 mem_clk  in  1  sole clock; all state updates on rising edge.
REQ-005 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-006 instr_req  in  1  core requests the instruction at instr_addr.
REQ-007 instr_addr  in  DDR_ADDR_WIDTH  core program counter (word address).
REQ-008 flush  in  1  invalidate the held block.
REQ-009 instr_out  out  ISA_WIDTH  instruction returned to core.
REQ-010 instr_valid  out  1  instr_out valid, one-cycle pulse.
REQ-011 ddr_rdy  in  1  DDR interface preload finished; no fill is requested while 0.
REQ-012 ISA_read_req  out  1  level fill request to the DDR interface.
REQ-013 ISA_read_addr  out  DDR_ADDR_WIDTH  fill start address (block base).
REQ-014 isa_read_len  out  10  fill length, constant ISA_DEPTH.
REQ-015 instruction_to_cache  in  ISA_WIDTH  returned word.
REQ-016 rd_cnt_isa  in  10  returned-word count, 1-based; returns to 0 at burst end.

Function
REQ-017 Storage: one block of ISA_DEPTH words, a block tag (instr_addr with low log2(ISA_DEPTH) bits cleared) and a valid bit.
REQ-018 States: IDLE, LOOKUP, MISS_REQ, FILL, DONE; reset state IDLE.
REQ-019 IDLE: instr_req=1 latches instr_addr and moves to LOOKUP.
REQ-020 LOOKUP hit (valid=1, tag match): instr_out = word[addr offset] and instr_valid=1 on the next edge, back to IDLE; hit latency is 2 cycles from instr_req to instr_valid.
REQ-021 LOOKUP miss: load ISA_read_addr with the latched block base and move to MISS_REQ.
REQ-022 MISS_REQ: ISA_read_req is held at 1 while ddr_rdy=1; it stays 0 while ddr_rdy=0.
REQ-023 ISA_read_req drops to 0 on the first edge that observes rd_cnt_isa != 0, which is also the transition to FILL.
REQ-024 FILL: a word is written when rd_cnt_isa is nonzero and differs from its value on the previous cycle.
REQ-025 FILL write: word[rd_cnt_isa-1] = instruction_to_cache.
REQ-026 FILL write counter: 10 bits; at count = ISA_DEPTH, set valid and the tag and go to DONE.
REQ-027 DONE: return the requested word with instr_valid=1, then go to IDLE.
REQ-028 rd_cnt_isa values greater than ISA_DEPTH are ignored.
REQ-029 instr_req while not in IDLE is ignored; the core holds instr_req until instr_valid.
REQ-030 flush in IDLE or LOOKUP clears valid at once; a flush in LOOKUP forces a miss.
REQ-031 flush during MISS_REQ or FILL: the burst runs to completion and valid stays 0 at DONE; the requested word is still returned.
REQ-032 Simultaneous flush and instr_req in IDLE: flush takes effect first, so the request misses.

Reset
REQ-033 rst_n=0 clears outputs asynchronously: ISA_read_req=0, ISA_read_addr=0, instr_valid=0, instr_out=0, isa_read_len=ISA_DEPTH.
REQ-034 rst_n=0 also clears valid, the tag, the write counter and the previous-count register, and sets state to IDLE; block contents are not cleared.
REQ-035 Reset mid-fill abandons the fill; the block is left invalid.

Configuration
REQ-036 Macro ISA_CACHE_STATS_EN, when defined, adds outputs hit_cnt[15:0] and miss_cnt[15:0].
REQ-037 hit_cnt and miss_cnt count LOOKUP outcomes, saturate at 16'hFFFF and reset to 0.
REQ-038 Without ISA_CACHE_STATS_EN, these ports and counters do not exist and behaviour is otherwise identical.

Verification
REQ-039 Cold miss: ddr_rdy=1, instr_req with addr 0x0000005 -> ISA_read_req=1, ISA_read_addr=0x0000000, isa_read_len=64; after 64 words instr_out = word 5.
REQ-040 Hit after fill: instr_req with addr 0x000003F -> instr_valid exactly 2 cycles later, no ISA_read_req.
REQ-041 ddr_rdy gating: ddr_rdy=0 for 100 cycles after a miss -> ISA_read_req stays 0; ISA_read_req asserts the cycle after ddr_rdy rises.
REQ-042 Stalled counter: rd_cnt_isa holds at 7 for 3 cycles -> exactly one write to word 6; word 7 is not written.
REQ-043 flush at the 10th fill word -> fill completes and addr 0x0000002 is returned, but a repeat request misses again.
REQ-044 With ISA_CACHE_STATS_EN: 1 miss then 3 hits -> miss_cnt=1, hit_cnt=3; rst_n low -> both 0.

Source files
------------

// File: rtl/isa_cache_fill_if.sv
// Bundles the core fetch port and the DDR fill port of isa_cache_fill.
// master: the cache itself; slave: the surrounding core/DDR environment.
interface isa_cache_fill_if #(
    parameter int ISA_WIDTH      = 30,
    parameter int DDR_ADDR_WIDTH = 28
);
    // Core side: instr_req is held by the core until instr_valid pulses for one
    // cycle; requests arriving while a lookup/fill is in flight are not accepted.
    // DDR side: ISA_read_req is a level held until the first nonzero rd_cnt_isa.
    logic                      instr_req;
    logic [DDR_ADDR_WIDTH-1:0] instr_addr;
    logic                      flush;
    logic [ISA_WIDTH-1:0]      instr_out;
    logic                      instr_valid;
    logic                      ddr_rdy;
    logic                      ISA_read_req;
    logic [DDR_ADDR_WIDTH-1:0] ISA_read_addr;
    logic [9:0]                isa_read_len;
    logic [ISA_WIDTH-1:0]      instruction_to_cache;
    logic [9:0]                rd_cnt_isa;

    modport master (
        input  instr_req, instr_addr, flush, ddr_rdy, instruction_to_cache, rd_cnt_isa,
        output instr_out, instr_valid, ISA_read_req, ISA_read_addr, isa_read_len
    );

    modport slave (
        output instr_req, instr_addr, flush, ddr_rdy, instruction_to_cache, rd_cnt_isa,
        input  instr_out, instr_valid, ISA_read_req, ISA_read_addr, isa_read_len
    );
endinterface

// File: rtl/isa_cache_fill.sv
// Single-block instruction cache refilled by DDR bursts of ISA_DEPTH words.
// Optional hit/miss counters are enabled by defining ISA_CACHE_STATS_EN.
module isa_cache_fill #(
    parameter int ISA_WIDTH      = 30,
    parameter int DDR_ADDR_WIDTH = 28,
    parameter int ISA_DEPTH      = 64
) (
    input  logic                  mem_clk,
    input  logic                  rst_n,
    isa_cache_fill_if.master      bus,
    output logic [2:0]            state_dbg
`ifdef ISA_CACHE_STATS_EN
    ,
    output logic [15:0]           hit_cnt,
    output logic [15:0]           miss_cnt
`endif
);
    localparam int OFF_W = $clog2(ISA_DEPTH);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        LOOKUP   = 3'd1,
        MISS_REQ = 3'd2,
        FILL     = 3'd3,
        DONE     = 3'd4
    } state_t;

    state_t                    state, state_nxt;
    logic [DDR_ADDR_WIDTH-1:0] addr_q;
    logic [DDR_ADDR_WIDTH-1:0] tag_q;
    logic                      valid_q;
    logic                      flush_pend;
    logic [9:0]                wr_cnt;
    logic [9:0]                prev_cnt;
    logic [ISA_WIDTH-1:0]      mem [ISA_DEPTH];

    logic [DDR_ADDR_WIDTH-1:0] base_addr;
    logic [OFF_W-1:0]          offset;
    logic [9:0]                wr_idx;
    logic                      hit;
    logic                      cnt_new;
    logic                      wr_en;
    logic                      fill_last;

    assign base_addr = {addr_q[DDR_ADDR_WIDTH-1:OFF_W], {OFF_W{1'b0}}};
    assign offset    = addr_q[OFF_W-1:0];
    assign wr_idx    = bus.rd_cnt_isa - 10'd1;
    assign hit       = valid_q && (tag_q == base_addr) && !bus.flush;
    // A word lands only on a fresh in-range count; a stalled count or an
    // out-of-range count writes nothing and does not advance the fill.
    assign cnt_new   = (bus.rd_cnt_isa != 10'd0) && (bus.rd_cnt_isa != prev_cnt)
                       && (bus.rd_cnt_isa <= 10'(ISA_DEPTH));
    assign wr_en     = ((state == MISS_REQ) || (state == FILL)) && cnt_new;
    assign fill_last = wr_en && (wr_cnt == 10'(ISA_DEPTH - 1));

    assign bus.isa_read_len = 10'(ISA_DEPTH);
    assign state_dbg        = state;

    always_ff @(posedge mem_clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:     if (bus.instr_req) state_nxt = LOOKUP;
            LOOKUP:   state_nxt = hit ? IDLE : MISS_REQ;
            MISS_REQ: if (bus.rd_cnt_isa != 10'd0) state_nxt = FILL;
            FILL:     if (fill_last) state_nxt = DONE;
            DONE:     state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    // Block storage has no reset; only the valid bit says whether it is usable.
    always_ff @(posedge mem_clk) begin
        if (wr_en) mem[wr_idx[OFF_W-1:0]] <= bus.instruction_to_cache;
    end

    always_ff @(posedge mem_clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.instr_out     <= '0;
            bus.instr_valid   <= 1'b0;
            bus.ISA_read_req  <= 1'b0;
            bus.ISA_read_addr <= '0;
            addr_q            <= '0;
            tag_q             <= '0;
            valid_q           <= 1'b0;
            flush_pend        <= 1'b0;
            wr_cnt            <= '0;
            prev_cnt          <= '0;
`ifdef ISA_CACHE_STATS_EN
            hit_cnt           <= '0;
            miss_cnt          <= '0;
`endif
        end else begin
            bus.instr_valid <= 1'b0;
            prev_cnt        <= bus.rd_cnt_isa;
            if (wr_en) wr_cnt <= wr_cnt + 10'd1;
            if (bus.flush && ((state == MISS_REQ) || (state == FILL))) flush_pend <= 1'b1;
            case (state)
                IDLE: begin
                    if (bus.flush)     valid_q <= 1'b0;
                    if (bus.instr_req) addr_q  <= bus.instr_addr;
                end
                LOOKUP: begin
                    if (hit) begin
                        bus.instr_out   <= mem[offset];
                        bus.instr_valid <= 1'b1;
                    end else begin
                        // The block is about to be overwritten, so drop it now.
                        bus.ISA_read_addr <= base_addr;
                        valid_q           <= 1'b0;
                        flush_pend        <= 1'b0;
                        wr_cnt            <= '0;
                    end
`ifdef ISA_CACHE_STATS_EN
                    if (hit && (hit_cnt != 16'hFFFF))   hit_cnt  <= hit_cnt + 16'd1;
                    if (!hit && (miss_cnt != 16'hFFFF)) miss_cnt <= miss_cnt + 16'd1;
`endif
                end
                MISS_REQ: begin
                    bus.ISA_read_req <= bus.ddr_rdy && (bus.rd_cnt_isa == 10'd0);
                end
                FILL: begin
                    if (fill_last) begin
                        valid_q <= !(flush_pend || bus.flush);
                        tag_q   <= base_addr;
                        wr_cnt  <= '0;
                    end
                end
                DONE: begin
                    bus.instr_out   <= mem[offset];
                    bus.instr_valid <= 1'b1;
                    if (bus.flush) valid_q <= 1'b0;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_isa_cache_fill.sv
// Directed bench for isa_cache_fill: cold miss, hits, ddr_rdy gating, stalled
// and out-of-range counts, flush during fill, flush with request, reset mid-fill.
module tb_isa_cache_fill;
    localparam int IW    = 30;
    localparam int AW    = 28;
    localparam int DEPTH = 64;

    logic       mem_clk = 1'b0;
    logic       rst_n;
    logic [2:0] state_dbg;
    int         n_checks = 0;
    int         n_errors = 0;
    logic [5:0] gen;
`ifdef ISA_CACHE_STATS_EN
    logic [15:0] hit_cnt, miss_cnt;
`endif
    int exp_hits   = 0;
    int exp_misses = 0;

    isa_cache_fill_if #(.ISA_WIDTH(IW), .DDR_ADDR_WIDTH(AW)) bus ();

    isa_cache_fill #(.ISA_WIDTH(IW), .DDR_ADDR_WIDTH(AW), .ISA_DEPTH(DEPTH)) dut (
        .mem_clk   (mem_clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .state_dbg (state_dbg)
`ifdef ISA_CACHE_STATS_EN
        ,
        .hit_cnt   (hit_cnt),
        .miss_cnt  (miss_cnt)
`endif
    );

    // clock / watchdog
    always #5 mem_clk = ~mem_clk;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Word content carries a generation tag so stale data is distinguishable.
    function automatic logic [IW-1:0] pat(input logic [5:0] g, input logic [AW-1:0] a);
        return {g, a[23:0]};
    endfunction

    task automatic start_req(input logic [AW-1:0] a, input logic with_flush);
        @(negedge mem_clk);
        bus.instr_req  = 1'b1;
        bus.instr_addr = a;
        bus.flush      = with_flush;
        @(negedge mem_clk);
        bus.flush      = 1'b0;
    endtask

    task automatic expect_hit(input string tag, input logic [AW-1:0] a, input logic [IW-1:0] exp);
        start_req(a, 1'b0);
        exp_hits++;
        check({tag, "_early"}, {31'd0, bus.instr_valid}, 32'd0);
        @(negedge mem_clk);
        check({tag, "_valid"}, {31'd0, bus.instr_valid}, 32'd1);
        check({tag, "_data"}, {2'd0, bus.instr_out}, {2'd0, exp});
        check({tag, "_noreq"}, {31'd0, bus.ISA_read_req}, 32'd0);
        bus.instr_req = 1'b0;
    endtask

    task automatic expect_miss(input string tag, input logic [AW-1:0] a, input logic with_flush,
                               input logic [AW-1:0] exp_base);
        logic seen;
        start_req(a, with_flush);
        exp_misses++;
        seen = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge mem_clk);
            if (bus.ISA_read_req) begin
                seen = 1'b1;
                break;
            end
        end
        check({tag, "_req"}, {31'd0, seen}, 32'd1);
        check({tag, "_addr"}, {4'd0, bus.ISA_read_addr}, {4'd0, exp_base});
        check({tag, "_len"}, {22'd0, bus.isa_read_len}, DEPTH);
    endtask

    // DDR driver: counts 1..nwords, with an optional stall, out-of-range count and flush.
    task automatic burst(input logic [AW-1:0] base, input logic [5:0] g, input int nwords,
                         input int stall_at, input int junk_at, input int flush_at);
        logic [AW-1:0] a;
        for (int i = 1; i <= nwords; i++) begin
            @(negedge mem_clk);
            if (i == 2) begin
                check("burst_req_drop", {31'd0, bus.ISA_read_req}, 32'd0);
                check("burst_state_fill", {29'd0, state_dbg}, 32'd3);
            end
            a = base + AW'(i - 1);
            bus.rd_cnt_isa           = 10'(i);
            bus.instruction_to_cache = pat(g, a);
            bus.flush                = (i == flush_at);
            if (i == stall_at) begin
                repeat (2) begin
                    @(negedge mem_clk);
                    bus.flush                = 1'b0;
                    bus.instruction_to_cache = ~pat(g, a);
                end
            end
            if (i == junk_at) begin
                @(negedge mem_clk);
                bus.flush                = 1'b0;
                bus.rd_cnt_isa           = 10'd100;
                bus.instruction_to_cache = '1;
            end
        end
        @(negedge mem_clk);
        bus.rd_cnt_isa = 10'd0;
        bus.flush      = 1'b0;
    endtask

    task automatic wait_valid(input string tag, input logic [IW-1:0] exp);
        logic found;
        found = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge mem_clk);
            if (bus.instr_valid) begin
                found = 1'b1;
                break;
            end
        end
        check({tag, "_valid"}, {31'd0, found}, 32'd1);
        check({tag, "_data"}, {2'd0, bus.instr_out}, {2'd0, exp});
        bus.instr_req = 1'b0;
    endtask

    initial begin
        logic seen;
        bus.instr_req            = 1'b0;
        bus.instr_addr           = '0;
        bus.flush                = 1'b0;
        bus.ddr_rdy              = 1'b1;
        bus.instruction_to_cache = '0;
        bus.rd_cnt_isa           = '0;
        rst_n                    = 1'b0;
        repeat (3) @(negedge mem_clk);

        check("rst_read_req", {31'd0, bus.ISA_read_req}, 32'd0);
        check("rst_read_addr", {4'd0, bus.ISA_read_addr}, 32'd0);
        check("rst_valid", {31'd0, bus.instr_valid}, 32'd0);
        check("rst_out", {2'd0, bus.instr_out}, 32'd0);
        check("rst_len", {22'd0, bus.isa_read_len}, 32'd64);
        check("rst_state", {29'd0, state_dbg}, 32'd0);
        rst_n = 1'b1;

        // cold miss at 0x5, with the count stalled at 7 for three cycles
        gen = 6'd1;
        expect_miss("cold", 28'h0000005, 1'b0, 28'h0000000);
        burst(28'h0000000, gen, DEPTH, 7, 0, 0);
        wait_valid("cold_ret", pat(gen, 28'h0000005));
        expect_hit("hit_3f", 28'h000003F, pat(gen, 28'h000003F));
        expect_hit("hit_06", 28'h0000006, pat(gen, 28'h0000006));
        expect_hit("hit_07", 28'h0000007, pat(gen, 28'h0000007));
        expect_hit("hit_00", 28'h0000000, pat(gen, 28'h0000000));

        // ddr_rdy low for 100 cycles holds off the request
        gen = 6'd2;
        bus.ddr_rdy = 1'b0;
        start_req(28'h0000045, 1'b0);
        exp_misses++;
        seen = 1'b0;
        repeat (100) begin
            @(negedge mem_clk);
            if (bus.ISA_read_req) seen = 1'b1;
        end
        check("gate_held", {31'd0, seen}, 32'd0);
        bus.ddr_rdy = 1'b1;
        @(negedge mem_clk);
        check("gate_rise", {31'd0, bus.ISA_read_req}, 32'd1);
        check("gate_addr", {4'd0, bus.ISA_read_addr}, 32'h40);
        burst(28'h0000040, gen, DEPTH, 0, 30, 0);
        wait_valid("gate_ret", pat(gen, 28'h0000045));
        expect_hit("hit_7f", 28'h000007F, pat(gen, 28'h000007F));
        expect_hit("hit_5f", 28'h000005F, pat(gen, 28'h000005F));

        // flush at the 10th word: word still returned, block not kept
        gen = 6'd3;
        expect_miss("fl", 28'h0000082, 1'b0, 28'h0000080);
        burst(28'h0000080, gen, DEPTH, 0, 0, 10);
        wait_valid("fl_ret", pat(gen, 28'h0000082));
        gen = 6'd4;
        expect_miss("fl_again", 28'h0000082, 1'b0, 28'h0000080);
        burst(28'h0000080, gen, DEPTH, 0, 0, 0);
        wait_valid("fl_again_ret", pat(gen, 28'h0000082));
        expect_hit("hit_83", 28'h0000083, pat(gen, 28'h0000083));

        // flush together with the request: flush wins, request misses
        gen = 6'd5;
        expect_miss("flreq", 28'h0000084, 1'b1, 28'h0000080);
        burst(28'h0000080, gen, DEPTH, 0, 0, 0);
        wait_valid("flreq_ret", pat(gen, 28'h0000084));
        expect_hit("hit_bf", 28'h00000BF, pat(gen, 28'h00000BF));

`ifdef ISA_CACHE_STATS_EN
        check("stat_hits", {16'd0, hit_cnt}, exp_hits);
        check("stat_misses", {16'd0, miss_cnt}, exp_misses);
`endif

        // reset in the middle of a fill
        gen = 6'd6;
        expect_miss("mid", 28'h0000100, 1'b0, 28'h0000100);
        burst(28'h0000100, gen, 20, 0, 0, 0);
        bus.rd_cnt_isa = 10'd20;
        #2;
        rst_n          = 1'b0;
        bus.instr_req  = 1'b0;
        bus.rd_cnt_isa = 10'd0;
        #1;
        check("mid_rst_req", {31'd0, bus.ISA_read_req}, 32'd0);
        check("mid_rst_addr", {4'd0, bus.ISA_read_addr}, 32'd0);
        check("mid_rst_state", {29'd0, state_dbg}, 32'd0);
        check("mid_rst_out", {2'd0, bus.instr_out}, 32'd0);
`ifdef ISA_CACHE_STATS_EN
        check("mid_rst_hits", {16'd0, hit_cnt}, 32'd0);
        check("mid_rst_misses", {16'd0, miss_cnt}, 32'd0);
`endif
        exp_hits   = 0;
        exp_misses = 0;
        @(negedge mem_clk);
        rst_n = 1'b1;
        gen = 6'd7;
        expect_miss("post_rst", 28'h0000100, 1'b0, 28'h0000100);
        burst(28'h0000100, gen, DEPTH, 0, 0, 0);
        wait_valid("post_rst_ret", pat(gen, 28'h0000100));
        expect_hit("hit_13f", 28'h000013F, pat(gen, 28'h000013F));
`ifdef ISA_CACHE_STATS_EN
        check("stat_hits_end", {16'd0, hit_cnt}, exp_hits);
        check("stat_misses_end", {16'd0, miss_cnt}, exp_misses);
`endif

        repeat (2) @(negedge mem_clk);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
